qarmav2_tweak_sched: RTL and testbench
======================================

Name: qarmav2_tweak_sched

Overview:
Iterative tweak-schedule engine for the QARMAv2-64 round datapath. It holds the 64-bit tweak in a register and presents one round tweak per round. On each round-advance request it updates the register with the tweak cell permutation (encrypt) or its inverse (decrypt). In decrypt mode it first pre-rolls the tweak forward to its last-round value, so the round datapath consumes tweaks in reverse order without a second storage copy.

Parameters:
ROUNDS, 9, number of round tweaks delivered per operation (1..15)
W, 64, tweak width; fixed 16 cells x 4 bits, no other value supported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin operation; sampled only in IDLE
dec  input  1  direction, sampled with start: 0 = encrypt, 1 = decrypt
tweak_in  input  64  initial tweak T, sampled with start
step  input  1  round datapath consumed current tweak_out; advance
abort  input  1  return to IDLE next cycle from any state
tweak_out  output  64  current round tweak (registered)
round_idx  output  4  index of current round tweak, 0..ROUNDS-1
valid  output  1  tweak_out/round_idx meaningful
last  output  1  valid && round_idx == ROUNDS-1
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst). rst has priority over all other inputs.
- Reset values: state IDLE; tweak_out, round_idx, valid, last and busy all 0. Internal pre-roll counter 0.
- Cell numbering: cell 0 = bits [63:60] … cell 15 = bits [3:0].
- Forward permutation P: out cell i = in cell p[i], with p = 1,10,14,6,2,9,13,5,0,8,12,4,3,11,15,7.
- Inverse permutation Pinv: out cell i = in cell q[i], with q = 8,0,4,12,11,7,3,15,9,5,1,13,10,6,2,14.
- P and Pinv are pure wiring inside the block. Exactly one P or Pinv is applied per clock.
- States:
  - IDLE:
    - On start: load tweak_out <= tweak_in, round_idx <= 0, latch dec.
    - If dec=0, or ROUNDS=1: go to RUN.
    - Otherwise go to PRE, with the pre-roll counter cleared.
  - PRE:
    - Each cycle: tweak_out <= P(tweak_out), counter++.
    - On the cycle of the (ROUNDS-1)th application, go to RUN.
    - valid=0 and step is ignored while in PRE.
  - RUN:
    - valid=1.
    - On step with round_idx < ROUNDS-1: tweak_out <= latched dec ? Pinv(tweak_out) : P(tweak_out), round_idx++.
    - On step with round_idx == ROUNDS-1: go to IDLE. valid, last and round_idx are cleared; tweak_out holds its value.
- Latency: if start is sampled in cycle N, the first valid cycle is N+1 (encrypt) or N+ROUNDS (decrypt). In RUN the next tweak is visible the cycle after step.
- Ignored inputs:
  - start outside IDLE; dec and tweak_in are not re-sampled.
  - step outside RUN.
- abort: any state -> IDLE next cycle. valid, last and round_idx are cleared; the pre-roll counter is cleared. tweak_out holds.
- Simultaneous events:
  - abort with step: abort wins.
  - start arriving in the same cycle RUN exits to IDLE: ignored. A new start is accepted from the first IDLE cycle.
- Reset mid-PRE or mid-RUN: IDLE next cycle, with all reset values applied.
- round_idx never exceeds ROUNDS-1.
- tweak_out changes only on load, in PRE, on step, or on rst.

Test Plan:
- Reset: assert rst with start=1 -> next cycle busy=0, valid=0, tweak_out=0, round_idx=0.
- Encrypt single step, ROUNDS=9:
  - start, dec=0, T=0x0123456789ABCDEF -> next cycle valid=1, tweak_out=0x0123456789ABCDEF, round_idx=0.
  - step -> tweak_out=0x1AE629D508C43BF7, round_idx=1.
- Encrypt full run: same T, step held high -> 9 valid cycles, last=1 only at round_idx=8, then busy=0. P has a single 16-cycle, so no earlier repeat of T.
- Decrypt pre-roll: start, dec=1, T=0x0123456789ABCDEF -> busy=1 and valid=0 for 8 cycles. valid rises at cycle N+9 with tweak_out=0x42170653BDE8F9AC, round_idx=0.
  - Then 8 steps -> tweak_out=0x0123456789ABCDEF at round_idx=8, with last=1.
  - Each intermediate value equals Pinv of the previous one.
- Handshake boundaries:
  - step during PRE, and start during RUN: no effect (value and index unchanged).
  - step gaps of 0–3 idle cycles: round_idx advances only on step.
- Abort and reset mid-operation:
  - abort at decrypt PRE cycle 3 -> IDLE next cycle, valid=0.
  - Immediate new encrypt start -> correct encrypt sequence.
  - rst at RUN round_idx=5 -> reset values.

Source files
------------

// File: rtl/qarmav2_tweak_sched.sv
// QARMAv2-64 tweak schedule: holds the tweak, presents one round tweak
// per step; decrypt pre-rolls forward so rounds are served in reverse.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, dec       begin operation (IDLE only), direction (1 = decrypt)
//   tweak_in         initial tweak, sampled with start
//   step             current tweak consumed, advance (RUN only)
//   abort            back to IDLE next cycle, tweak_out holds
//   tweak_out        current round tweak (registered)
//   round_idx        index of current round tweak
//   valid, last      tweak_out meaningful / final round tweak
//   busy             not IDLE
module qarmav2_tweak_sched #(
    parameter int ROUNDS = 9,
    parameter int W      = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dec,
    input  logic [W-1:0] tweak_in,
    input  logic         step,
    input  logic         abort,
    output logic [W-1:0] tweak_out,
    output logic [3:0]   round_idx,
    output logic         valid,
    output logic         last,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);
    // Pre-roll ends on its (ROUNDS-1)th application; only reached
    // when ROUNDS >= 2.
    localparam logic [3:0] PRE_END  = 4'(ROUNDS - 2);

    // Source cell for each output cell; cell 0 is the top nibble.
    localparam logic [3:0] P_TAB [16] = '{
        4'd1, 4'd10, 4'd14, 4'd6, 4'd2, 4'd9, 4'd13, 4'd5,
        4'd0, 4'd8, 4'd12, 4'd4, 4'd3, 4'd11, 4'd15, 4'd7
    };
    localparam logic [3:0] Q_TAB [16] = '{
        4'd8, 4'd0, 4'd4, 4'd12, 4'd11, 4'd7, 4'd3, 4'd15,
        4'd9, 4'd5, 4'd1, 4'd13, 4'd10, 4'd6, 4'd2, 4'd14
    };

    logic [1:0]   state_q, state_d;
    logic [W-1:0] tweak_q, tweak_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         dec_q, dec_d;

    logic [W-1:0] perm_fwd;
    logic [W-1:0] perm_inv;

    for (genvar i = 0; i < 16; i++) begin : g_perm
        assign perm_fwd[W-1-4*i -: 4] = tweak_q[W-1-4*int'(P_TAB[i]) -: 4];
        assign perm_inv[W-1-4*i -: 4] = tweak_q[W-1-4*int'(Q_TAB[i]) -: 4];
    end

    always_comb begin
        state_d = state_q;
        tweak_d = tweak_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tweak_d = tweak_in;
                        idx_d   = 4'd0;
                        cnt_d   = 4'd0;
                        dec_d   = dec;
                        state_d = (!dec || ROUNDS == 1) ? S_RUN : S_PRE;
                    end
                end
                S_PRE: begin
                    tweak_d = perm_fwd;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == PRE_END) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            idx_d   = 4'd0;
                        end else begin
                            tweak_d = dec_q ? perm_inv : perm_fwd;
                            idx_d   = idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tweak_q <= '0;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tweak_q <= tweak_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    assign tweak_out = tweak_q;
    assign round_idx = idx_q;
    assign valid     = (state_q == S_RUN);
    assign last      = valid && (idx_q == LAST_IDX);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_qarmav2_tweak_sched.sv
// Scoreboard bench for qarmav2_tweak_sched: stimulus pushes expected
// round tweaks, a negedge monitor pops them on every consumed step.
module tb_qarmav2_tweak_sched;

    localparam int ROUNDS = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dec;
    logic [63:0] tweak_in;
    logic        step;
    logic        abort;
    logic [63:0] tweak_out;
    logic [3:0]  round_idx;
    logic        valid;
    logic        last;
    logic        busy;

    always #5 clk = ~clk;

    qarmav2_tweak_sched #(.ROUNDS(ROUNDS), .W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dec       (dec),
        .tweak_in  (tweak_in),
        .step      (step),
        .abort     (abort),
        .tweak_out (tweak_out),
        .round_idx (round_idx),
        .valid     (valid),
        .last      (last),
        .busy      (busy)
    );

    localparam logic [63:0] T_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] T_B = 64'hFEDCBA9876543210;

    // P^k(T_A), k = 0..8, worked out cell by cell along the 16-cycle of p.
    // T_B is the nibble-wise complement of T_A, so P^k(T_B) = ~P^k(T_A).
    localparam logic [63:0] PA [9] = '{
        64'h0123456789ABCDEF,
        64'h1AE629D508C43BF7,
        64'hACFDE8B910326475,
        64'hC37BF048A16ED259,
        64'h36547120CADFBE98,
        64'h6D925AE13CB74F80,
        64'hDB8E9CFA63452701,
        64'hB40F837CD629E51A,
        64'h42170653BDE8F9AC
    };

    typedef struct packed {
        logic [63:0] tw;
        logic [3:0]  idx;
        logic        lst;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] tw, input int r);
        exp_t x;
        x.tw  = tw;
        x.idx = 4'(r);
        x.lst = (r == ROUNDS - 1);
        sb.push_back(x);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && step && !abort) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty: got tweak %h idx %0d, expected none",
                         tweak_out, round_idx);
            end else begin
                e = sb.pop_front();
                if ({tweak_out, round_idx, last} !== e) begin
                    n_bad++;
                    $display("FAIL round: got %h/%0d/%b, expected %h/%0d/%b",
                             tweak_out, round_idx, last, e.tw, e.idx, e.lst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int nv;
        rst      = 1'b1;
        start    = 1'b1;
        dec      = 1'b0;
        tweak_in = T_A;
        step     = 1'b0;
        abort    = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_tweak", tweak_out, 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // Encrypt with step gaps of 0..3 and a stray start mid-run.
        start = 1'b1; dec = 1'b0; tweak_in = T_A;
        tick();
        start = 1'b0;
        chk("enc_first_valid", 64'(valid), 64'd1);
        chk("enc_first_tweak", tweak_out, T_A);
        chk("enc_first_idx", 64'(round_idx), 64'd0);
        for (int r = 0; r < ROUNDS; r++) push(PA[r], r);
        for (int r = 0; r < ROUNDS; r++) begin
            for (int g = 0; g < r % 4; g++) begin
                if (r == 2 && g == 0) begin
                    start = 1'b1; dec = 1'b1; tweak_in = T_B;
                end
                tick();
                start = 1'b0; dec = 1'b0; tweak_in = T_A;
                chk("gap_idx", 64'(round_idx), 64'(r));
            end
            do_step();
            if (r == 0) begin
                chk("enc_step1_tweak", tweak_out, PA[1]);
                chk("enc_step1_idx", 64'(round_idx), 64'd1);
            end
        end
        chk("enc_gap_done", 64'(busy), 64'd0);
        chk("enc_gap_hold", tweak_out, PA[8]);
        tick();

        // Encrypt with step held high; start on the exit cycle is ignored.
        start = 1'b1; dec = 1'b0; tweak_in = T_A;
        tick();
        start = 1'b0;
        for (int r = 0; r < ROUNDS; r++) push(PA[r], r);
        step = 1'b1;
        nv = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            if (valid) nv++;
            if (last) begin
                chk("full_last_idx", 64'(round_idx), 64'd8);
                start = 1'b1; tweak_in = T_B;
            end
            tick();
        end
        step = 1'b0; start = 1'b0; tweak_in = T_A;
        chk("full_valid_cycles", 64'(nv), 64'd9);
        chk("full_exit_idle", 64'(busy), 64'd0);
        chk("full_hold", tweak_out, PA[8]);
        tick();
        chk("full_start_ignored", 64'(busy), 64'd0);

        // Decrypt: 8 pre-roll cycles with step ignored, then reverse order.
        start = 1'b1; dec = 1'b1; tweak_in = T_A;
        tick();
        start = 1'b0; dec = 1'b0;
        for (int i = 0; i < ROUNDS - 1; i++) begin
            chk("pre_busy", 64'(busy), 64'd1);
            chk("pre_valid", 64'(valid), 64'd0);
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        chk("dec_first_valid", 64'(valid), 64'd1);
        chk("dec_first_tweak", tweak_out, PA[8]);
        chk("dec_first_idx", 64'(round_idx), 64'd0);
        for (int r = 0; r < ROUNDS; r++) push(PA[ROUNDS - 1 - r], r);
        for (int r = 0; r < ROUNDS; r++) do_step();
        chk("dec_done", 64'(busy), 64'd0);
        chk("dec_hold", tweak_out, T_A);
        tick();

        // Abort on pre-roll cycle 3, after two applications of P.
        start = 1'b1; dec = 1'b1; tweak_in = T_B;
        tick();
        start = 1'b0; dec = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_tweak", tweak_out, 64'h53021746EFCD9B8A);

        // Immediate encrypt, then abort together with step at round 4.
        start = 1'b1; dec = 1'b0; tweak_in = T_B;
        tick();
        start = 1'b0;
        chk("reenc_tweak", tweak_out, T_B);
        for (int r = 0; r < 4; r++) push(~PA[r], r);
        for (int r = 0; r < 4; r++) do_step();
        chk("reenc_idx4", 64'(round_idx), 64'd4);
        abort = 1'b1; step = 1'b1;
        tick();
        abort = 1'b0; step = 1'b0;
        chk("abort_step_busy", 64'(busy), 64'd0);
        chk("abort_step_idx", 64'(round_idx), 64'd0);
        chk("abort_step_hold", tweak_out, 64'hC9AB8EDF35204167);

        // Reset in RUN at round 5.
        start = 1'b1; dec = 1'b0; tweak_in = T_A;
        tick();
        start = 1'b0;
        for (int r = 0; r < 5; r++) push(PA[r], r);
        for (int r = 0; r < 5; r++) do_step();
        chk("run5_idx", 64'(round_idx), 64'd5);
        chk("run5_tweak", tweak_out, PA[5]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_tweak", tweak_out, 64'd0);
        chk("mid_rst_idx", 64'(round_idx), 64'd0);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
